// File: rtl/memorio_bridge.sv
// Data-path bridge between the load/store stage, a synchronous data RAM and memory-mapped board I/O.
// Optional seven-segment register is enabled by defining MEMORIO_SEG7_EN.
module memorio_bridge #(
  parameter int          RAM_AW     = 14,
  parameter logic [21:0] IO_BASE_HI = 22'h3fffff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       switch_in,
  output logic [15:0]       led_out
`ifdef MEMORIO_SEG7_EN
  ,
  output logic [31:0]       seg_data
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic [9:0] LED_OFS = 10'h060;
  localparam logic [9:0] SW_OFS  = 10'h070;
`ifdef MEMORIO_SEG7_EN
  localparam logic [9:0] SEG_OFS = 10'h080;
`endif

  state_e      state_q, state_d;
  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q, sw_sync_q;
`ifdef MEMORIO_SEG7_EN
  logic [31:0] seg_q, seg_d;
`endif

  logic io_region;
  logic led_hit;
  logic sw_hit;

  assign io_region = (addr[31:10] == IO_BASE_HI);
  assign led_hit   = io_region && (addr[9:0] == LED_OFS);
  assign sw_hit    = io_region && (addr[9:0] == SW_OFS);

  // Every RAM access is a word access; the byte offset is dropped.
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // NOTE: every output and next-state is given a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
`ifdef MEMORIO_SEG7_EN
    seg_d   = seg_q;
`endif
    rdata   = 32'h0;
    stall   = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;

    // Strobes are held quiet while reset is asserted, even mid-load.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (io_write) begin
            if (led_hit) led_d = wdata[15:0];
`ifdef MEMORIO_SEG7_EN
            if (io_region && (addr[9:0] == SEG_OFS)) seg_d = wdata;
`endif
          end else if (io_read) begin
            if (sw_hit) rdata = {16'h0, sw_sync_q};
          end else if (mem_write) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else if (mem_read) begin
            ram_en  = 1'b1;
            stall   = 1'b1;
            state_d = RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata   = ram_rdata;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      led_q     <= 16'h0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
`ifdef MEMORIO_SEG7_EN
      seg_q     <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
`ifdef MEMORIO_SEG7_EN
      seg_q     <= seg_d;
`endif
    end
  end

  assign led_out = led_q;
`ifdef MEMORIO_SEG7_EN
  assign seg_data = seg_q;
`endif

endmodule

// File: tb/tb_memorio_bridge.sv
// Self-checking bench for memorio_bridge: directed vector table, a reset corner sequence,
// then randomized traffic against a request-level reference model.
module tb_memorio_bridge;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write, io_read, io_write;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata;
  logic          stall, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [15:0]   switch_in;
  logic [15:0]   led_out;
`ifdef MEMORIO_SEG7_EN
  logic [31:0]   seg_data;
`endif

  always #5 clk = ~clk;

  memorio_bridge #(.RAM_AW(AW), .IO_BASE_HI(22'h3fffff)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .switch_in (switch_in),
    .led_out   (led_out)
`ifdef MEMORIO_SEG7_EN
    ,
    .seg_data  (seg_data)
`endif
  );

  // Behavioural synchronous RAM attached to the bridge.
  logic [31:0] tb_ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) tb_ram[ram_addr] <= ram_wdata;
      else        ram_rdata        <= tb_ram[ram_addr];
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: word memory as seen by completed writes, plus architectural registers.
  bit [31:0] mdl_mem   [0:(1<<AW)-1];
  bit        mdl_valid [0:(1<<AW)-1];
  bit        mdl_pending;
  bit [AW-1:0] mdl_word;
  bit [15:0] mdl_led;
  bit [31:0] mdl_seg;
  bit [15:0] sw_hist[$];

  function automatic bit in_io(input logic [31:0] a);
    return a[31:10] == 22'h3fffff;
  endfunction

  task automatic drive(input logic r, input logic mr, input logic mw, input logic ir, input logic iw,
                       input logic [31:0] a, input logic [31:0] d, input logic [15:0] sw);
    rst = r; mem_read = mr; mem_write = mw; io_read = ir; io_write = iw;
    addr = a; wdata = d; switch_in = sw;
  endtask

  typedef struct {
    logic        r, mr, mw, ir, iw;
    logic [31:0] a, d;
    logic [15:0] sw;
    logic        e_stall, e_en, e_we;
    logic [31:0] e_rdata;
    logic [15:0] e_led;
    logic [31:0] e_seg;
    logic [AW-1:0] e_waddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic mr, input logic mw, input logic ir, input logic iw,
                              input logic [31:0] a, input logic [31:0] d, input logic [15:0] sw,
                              input logic es, input logic een, input logic ewe, input logic [31:0] erd,
                              input logic [15:0] eled, input logic [31:0] eseg, input logic [AW-1:0] ewa);
    vec_t v;
    v.r = r; v.mr = mr; v.mw = mw; v.ir = ir; v.iw = iw; v.a = a; v.d = d; v.sw = sw;
    v.e_stall = es; v.e_en = een; v.e_we = ewe; v.e_rdata = erd; v.e_led = eled;
    v.e_seg = eseg; v.e_waddr = ewa;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic es, input logic een, input logic ewe,
                               input logic [31:0] erd, input logic [15:0] eled, input logic [31:0] eseg);
    check({tag, ".stall"},  {31'h0, stall},  {31'h0, es});
    check({tag, ".ram_en"}, {31'h0, ram_en}, {31'h0, een});
    check({tag, ".ram_we"}, {31'h0, ram_we}, {31'h0, ewe});
    check({tag, ".rdata"},  rdata, erd);
    check({tag, ".led"},    {16'h0, led_out}, {16'h0, eled});
`ifdef MEMORIO_SEG7_EN
    check({tag, ".seg"},    seg_data, eseg);
`else
    if (eseg != 32'hFFFF_FFFF) begin end
`endif
  endtask

  initial begin
    logic [31:0] io_pool [6];
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // rst mr mw ir iw addr wdata sw | stall en we rdata led seg waddr
    tbl.push_back(mk(1,0,0,0,0, 32'h0,        32'h0,        16'h0,   0,0,0, 32'h0,        16'h0,    32'h0,  '0));
    tbl.push_back(mk(0,0,1,0,0, 32'h10,       32'hDEADBEEF, 16'h0,   0,1,1, 32'h0,        16'h0,    32'h0,  14'd4));
    tbl.push_back(mk(0,1,0,0,0, 32'h10,       32'h0,        16'h0,   1,1,0, 32'h0,        16'h0,    32'h0,  14'd4));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h0,   0,0,0, 32'hDEADBEEF, 16'h0,    32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,1, 32'hFFFFFC60, 32'h1234ABCD, 16'h0,   0,0,0, 32'h0,        16'h0,    32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'hABCD, 32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'hABCD, 32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'hABCD, 32'h0,  '0));
    tbl.push_back(mk(0,0,0,1,0, 32'hFFFFFC70, 32'h0,        16'h00F0,0,0,0, 32'h000000F0, 16'hABCD, 32'h0,  '0));
    tbl.push_back(mk(0,1,0,0,0, 32'h10,       32'h0,        16'h00F0,1,1,0, 32'h0,        16'hABCD, 32'h0,  14'd4));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'hABCD, 32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h0,  '0));
    tbl.push_back(mk(0,0,1,0,1, 32'hFFFFFC80, 32'h55,       16'h00F0,0,0,0, 32'h0,        16'h0,    32'h0,  '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));
    tbl.push_back(mk(0,1,0,0,0, 32'h13,       32'h0,        16'h00F0,1,1,0, 32'h0,        16'h0,    32'h55, 14'd4));
    tbl.push_back(mk(0,1,0,0,0, 32'h13,       32'h0,        16'h00F0,0,0,0, 32'hDEADBEEF, 16'h0,    32'h55, '0));
    tbl.push_back(mk(0,1,0,0,0, 32'h13,       32'h0,        16'h00F0,1,1,0, 32'h0,        16'h0,    32'h55, 14'd4));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'hDEADBEEF, 16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,0,1,0, 32'hFFFFFC60, 32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,0,0,1, 32'hFFFFFC64, 32'hFFFF,     16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,1,0,0, 32'hFFFFFC70, 32'hCAFEF00D, 16'h00F0,0,1,1, 32'h0,        16'h0,    32'h55, 14'h3F1C));
    tbl.push_back(mk(0,1,0,0,0, 32'hFFFFFC70, 32'h0,        16'h00F0,1,1,0, 32'h0,        16'h0,    32'h55, 14'h3F1C));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'hCAFEF00D, 16'h0,    32'h55, '0));
    tbl.push_back(mk(0,1,0,1,0, 32'hFFFFFC70, 32'h0,        16'h00F0,0,0,0, 32'h000000F0, 16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,0,1,1, 32'hFFFFFC70, 32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,        16'h00F0,0,0,0, 32'h0,        16'h0,    32'h55, '0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].r, tbl[i].mr, tbl[i].mw, tbl[i].ir, tbl[i].iw, tbl[i].a, tbl[i].d, tbl[i].sw);
      @(negedge clk);
      check_outputs($sformatf("tbl%0d", i), tbl[i].e_stall, tbl[i].e_en, tbl[i].e_we,
                    tbl[i].e_rdata, tbl[i].e_led, tbl[i].e_seg);
      if (tbl[i].e_en) check($sformatf("tbl%0d.ram_addr", i), {18'h0, ram_addr}, {18'h0, tbl[i].e_waddr});
      if (tbl[i].e_we) check($sformatf("tbl%0d.ram_wdata", i), ram_wdata, tbl[i].d);
      if (!tbl[i].r && !tbl[i].iw && !tbl[i].ir && tbl[i].mw) begin
        mdl_mem[tbl[i].a[AW+1:2]]   = tbl[i].d;
        mdl_valid[tbl[i].a[AW+1:2]] = 1'b1;
      end
    end

    // Reset held over a pending read request, then released with the request still high.
    @(posedge clk); #1; drive(1, 1, 0, 0, 0, 32'h10, 0, 16'h00F0);
    @(negedge clk); check_outputs("rsthold0", 0, 0, 0, 32'h0, 16'h0, 32'h55);
    @(posedge clk); #1; drive(1, 1, 0, 0, 0, 32'h10, 0, 16'h00F0);
    @(negedge clk); check_outputs("rsthold1", 0, 0, 0, 32'h0, 16'h0, 32'h0);
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 32'h10, 0, 16'h00F0);
    @(negedge clk); check_outputs("rstrel0", 1, 1, 0, 32'h0, 16'h0, 32'h0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 32'h0, 0, 16'h00F0);
    @(negedge clk); check_outputs("rstrel1", 0, 0, 0, 32'hDEADBEEF, 16'h0, 32'h0);

    // Randomized traffic against the request-level model.
    io_pool[0] = 32'hFFFFFC60; io_pool[1] = 32'hFFFFFC70; io_pool[2] = 32'hFFFFFC80;
    io_pool[3] = 32'hFFFFFC64; io_pool[4] = 32'hFFFFFC71; io_pool[5] = 32'h00000C70;
    for (int n = 0; n < 2000; n++) begin
      logic r, mr, mw, ir, iw;
      logic [31:0] a, d;
      logic [15:0] sw;
      logic es, een, ewe;
      logic [31:0] erd;
      bit [AW-1:0] w;
      bit chk_rd;

      r  = (n == 0) || ($urandom_range(0, 49) == 0);
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 2) == 0);
      ir = ($urandom_range(0, 2) == 0);
      iw = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        a = {$urandom_range(0, 16'hFFFF) & 32'hFFFF, 2'b00, 14'd256 + 14'($urandom_range(0, 15))}
            << 0;
      else
        a = io_pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) a = {a[31:16], 14'd256 + 14'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      sw = 16'($urandom);
      w  = a[AW+1:2];

      @(posedge clk); #1;
      drive(r, mr, mw, ir, iw, a, d, sw);

      es = 0; een = 0; ewe = 0; erd = 32'h0; chk_rd = 1'b1;
      if (!r) begin
        if (mdl_pending) begin
          erd    = mdl_mem[mdl_word];
          chk_rd = mdl_valid[mdl_word];
        end else if (iw) begin
        end else if (ir) begin
          if (in_io(a) && a[9:0] == 10'h070) erd = {16'h0, sw_hist[1]};
        end else if (mw) begin
          een = 1; ewe = 1;
        end else if (mr) begin
          een = 1; es = 1;
        end
      end

      @(negedge clk);
      check($sformatf("rnd%0d.stall", n),  {31'h0, stall},  {31'h0, es});
      check($sformatf("rnd%0d.ram_en", n), {31'h0, ram_en}, {31'h0, een});
      check($sformatf("rnd%0d.ram_we", n), {31'h0, ram_we}, {31'h0, ewe});
      if (chk_rd) check($sformatf("rnd%0d.rdata", n), rdata, erd);
      check($sformatf("rnd%0d.led", n), {16'h0, led_out}, {16'h0, mdl_led});
`ifdef MEMORIO_SEG7_EN
      check($sformatf("rnd%0d.seg", n), seg_data, mdl_seg);
`endif
      if (een) check($sformatf("rnd%0d.ram_addr", n), {18'h0, ram_addr}, {18'h0, w});
      if (ewe) check($sformatf("rnd%0d.ram_wdata", n), ram_wdata, d);

      // Advance the model across the coming edge.
      if (r) begin
        mdl_pending = 0; mdl_led = 0; mdl_seg = 0;
        sw_hist = '{16'h0, 16'h0};
      end else begin
        if (mdl_pending) mdl_pending = 0;
        else if (iw) begin
          if (in_io(a) && a[9:0] == 10'h060) mdl_led = d[15:0];
`ifdef MEMORIO_SEG7_EN
          if (in_io(a) && a[9:0] == 10'h080) mdl_seg = d;
`endif
        end else if (ir) begin
        end else if (mw) begin
          mdl_mem[w] = d; mdl_valid[w] = 1'b1;
        end else if (mr) begin
          mdl_pending = 1; mdl_word = w;
        end
        sw_hist.push_front(sw);
        void'(sw_hist.pop_back());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
